// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and sample constants for the tactile-array scan scheduler.
package scan_pkg;
  localparam int SAMPLE_W = 12;
  localparam int TAXEL_CNT = 16 * 16;
  typedef enum logic [3:0] {
    IDLE,
    SETTLE,
    CONVERT,
    WAIT_ADC,
    WRITE,
    NEXT,
    FRAME_DONE,
    HANDOFF
  } scan_state_t;
endpackage

// File: rtl/scan_settle_timer.sv
// scan_settle_timer: loadable down-counter that parks at zero; done is high while the count is zero.
module scan_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/scan_frame_scheduler.sv
// scan_frame_scheduler: walks every taxel through settle/convert/write into a ping-pong frame RAM
// and hands each finished bank to the UART.
module scan_frame_scheduler
  import scan_pkg::*;
#(
  parameter int SW_WIRE_CNT = 16,
  parameter int RD_WIRE_CNT = 16,
  parameter int SW_SETTLE   = 64,
  parameter int RD_SETTLE   = 8,
  parameter int ADC_TIMEOUT = 255,
  localparam int SWW = $clog2(SW_WIRE_CNT),
  localparam int RDW = $clog2(RD_WIRE_CNT),
  localparam int AW  = $clog2(SW_WIRE_CNT * RD_WIRE_CNT)
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                scan_enable,
  output logic [SWW-1:0]      sw_sel,
  output logic                sw_drive,
  output logic [RDW-1:0]      rd_sel,
  output logic                adc_start,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                buf_wr_en,
  output logic [AW:0]         buf_wr_addr,
  output logic [SAMPLE_W-1:0] buf_wr_data,
  output logic                rd_bank,
  output logic                uart_active,
  input  logic                uart_done,
  output logic [15:0]         frame_count,
  output logic                adc_timeout
);
  localparam int TMAX = SW_SETTLE > RD_SETTLE ? (SW_SETTLE > ADC_TIMEOUT ? SW_SETTLE : ADC_TIMEOUT)
                                              : (RD_SETTLE > ADC_TIMEOUT ? RD_SETTLE : ADC_TIMEOUT);
  localparam int TW = $clog2(TMAX + 1);
  logic rst_meta, rst_n;
  scan_state_t state;
  logic wr_bank, rd_wrap, sw_wrap, tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;
  // Reset asserts immediately but releases two clocks later, in step with clk_in.
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) {rst_n, rst_meta} <= 2'b00;
    else {rst_n, rst_meta} <= {rst_meta, 1'b1};
  assign rd_bank = ~wr_bank;
  assign rd_wrap = rd_sel == RDW'(RD_WIRE_CNT - 1);
  assign sw_wrap = sw_sel == SWW'(SW_WIRE_CNT - 1);
  // Loads coincide with the edge that enters SETTLE or WAIT_ADC; the -1/-2 offsets make
  // adc_start rise exactly settle cycles after a select change and the timeout write land
  // ADC_TIMEOUT cycles after adc_start.
  always_comb begin
    tmr_load = ((state == IDLE || state == HANDOFF) && scan_enable) || state == NEXT || state == CONVERT;
    tmr_val  = state == CONVERT ? TW'(ADC_TIMEOUT - 2)
             : (state == NEXT && !rd_wrap) ? TW'(RD_SETTLE - 1) : TW'(SW_SETTLE - 1);
  end
  scan_settle_timer #(.W(TW)) u_timer (
    .clk  (clk_in),
    .rst_n(rst_n),
    .load (tmr_load),
    .val  (tmr_val),
    .done (tmr_done)
  );
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      sw_sel      <= '0;
      rd_sel      <= '0;
      sw_drive    <= 1'b0;
      adc_start   <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      wr_bank     <= 1'b0;
      uart_active <= 1'b0;
      frame_count <= '0;
      adc_timeout <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      buf_wr_en <= 1'b0;
      if (uart_done) uart_active <= 1'b0;
      case (state)
        IDLE:
          if (scan_enable) begin
            state    <= SETTLE;
            sw_sel   <= '0;
            rd_sel   <= '0;
            sw_drive <= 1'b1;
          end
        SETTLE:
          if (tmr_done) begin
            state     <= CONVERT;
            adc_start <= 1'b1;
          end
        CONVERT: state <= WAIT_ADC;
        WAIT_ADC:
          if (adc_valid || tmr_done) begin
            state       <= WRITE;
            buf_wr_en   <= 1'b1;
            buf_wr_addr <= {wr_bank, AW'(sw_sel) * AW'(RD_WIRE_CNT) + AW'(rd_sel)};
            buf_wr_data <= adc_valid ? adc_data : '0;
            if (!adc_valid) adc_timeout <= 1'b1;
          end
        WRITE: state <= NEXT;
        NEXT: begin
          rd_sel <= rd_wrap ? '0 : rd_sel + 1'b1;
          if (rd_wrap) sw_sel <= sw_wrap ? '0 : sw_sel + 1'b1;
          state <= rd_wrap && sw_wrap ? FRAME_DONE : SETTLE;
          if (rd_wrap && sw_wrap) sw_drive <= 1'b0;
        end
        // Sees uart_active before any same-cycle uart_done clear, so the swap waits a cycle.
        FRAME_DONE:
          if (!uart_active) begin
            wr_bank     <= ~wr_bank;
            uart_active <= 1'b1;
            frame_count <= frame_count + 1'b1;
            state       <= HANDOFF;
          end
        HANDOFF: begin
          state    <= scan_enable ? SETTLE : IDLE;
          sw_drive <= scan_enable;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_scan_frame_scheduler.sv
// tb_scan_frame_scheduler: directed scenarios on a 4x4 array with a 3-cycle ADC model and
// hand-computed expectations for addresses, data, settle gaps, stalls, timeout and reset.
module tb_scan_frame_scheduler;
  logic        clk_in = 0, rst_n_in = 0, scan_enable = 0, adc_valid = 0, uart_done = 0;
  logic [11:0] adc_data = 0, buf_wr_data;
  logic [1:0]  sw_sel, rd_sel;
  logic        sw_drive, adc_start, buf_wr_en, rd_bank, uart_active, adc_timeout;
  logic [4:0]  buf_wr_addr;
  logic [15:0] frame_count;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pend = 0, pdata = 0, tax = 0, silent = -1, t0 = 0;
  int exp_idx = 0, nwrites = 0, gap = 0, base = 0;
  logic exp_bank = 0, gap_ok = 0, gap_row = 0, prev_start = 0;
  logic [1:0] prev_rd = 0;

  scan_frame_scheduler #(
    .SW_WIRE_CNT(4), .RD_WIRE_CNT(4), .SW_SETTLE(5), .RD_SETTLE(2), .ADC_TIMEOUT(10)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .scan_enable(scan_enable),
    .sw_sel(sw_sel), .sw_drive(sw_drive), .rd_sel(rd_sel), .adc_start(adc_start),
    .adc_valid(adc_valid), .adc_data(adc_data), .buf_wr_en(buf_wr_en),
    .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data), .rd_bank(rd_bank),
    .uart_active(uart_active), .uart_done(uart_done), .frame_count(frame_count),
    .adc_timeout(adc_timeout)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 3000 && nwrites < n; i++) @(negedge clk_in);
    chk("wait_writes", nwrites, n);
  endtask

  task automatic wait_active();
    for (int i = 0; i < 3000 && !uart_active; i++) @(negedge clk_in);
    chk("wait_active", uart_active, 1);
  endtask

  task automatic pulse_done();
    uart_done = 1;
    @(negedge clk_in);
    uart_done = 0;
  endtask

  // ADC model plus write/settle monitors, all sampled on the falling edge.
  always @(negedge clk_in) begin
    cyc++;
    if (!rst_n_in) begin
      pend = 0; adc_valid = 0; tax = 0; exp_idx = 0; exp_bank = 0;
      gap_ok = 0; prev_rd = 0; prev_start = 0;
    end else begin
      adc_valid = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          adc_valid = 1;
          adc_data = 12'(pdata);
        end
      end
      if (adc_start) begin
        chk("start_pulse", prev_start, 0);
        if (tax == silent) t0 = cyc;
        else begin
          pend = 3;
          pdata = tax;
        end
        tax = (tax + 1) % 16;
      end
      prev_start = adc_start;
      if (rd_sel != prev_rd) begin
        gap = 0;
        gap_ok = !(rd_sel == 0 && sw_sel == 0);
        gap_row = rd_sel == 0;
      end else gap++;
      if (adc_start && gap_ok) begin
        chk(gap_row ? "row_settle" : "col_settle", gap, gap_row ? 5 : 2);
        gap_ok = 0;
      end
      prev_rd = rd_sel;
      if (buf_wr_en) begin
        chk("wr_addr", buf_wr_addr, exp_bank * 16 + exp_idx);
        chk("wr_data", buf_wr_data, exp_idx == silent ? 0 : exp_idx);
        if (exp_idx == silent) chk("timeout_lat", cyc - t0, 10);
        nwrites++;
        exp_idx++;
        if (exp_idx == 16) begin
          exp_idx = 0;
          exp_bank = ~exp_bank;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_sw_drive", sw_drive, 0);
    chk("rst_wr_en", buf_wr_en, 0);
    chk("rst_uart", uart_active, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_rd_bank", rd_bank, 1);
    chk("rst_timeout", adc_timeout, 0);
    rst_n_in = 1;
    scan_enable = 1;
    // Frame 1: 16 ordered writes into bank 0, then handoff.
    wait_active();
    chk("f1_writes", nwrites, 16);
    chk("f1_count", frame_count, 1);
    chk("f1_rd_bank", rd_bank, 0);
    chk("f1_timeout", adc_timeout, 0);
    // Frame 2 stalls in FRAME_DONE until the UART reports done.
    wait_writes(32);
    repeat (30) @(negedge clk_in);
    chk("stall_writes", nwrites, 32);
    chk("stall_count", frame_count, 1);
    chk("stall_drive", sw_drive, 0);
    chk("stall_busy", uart_active, 1);
    pulse_done();
    chk("ua_clear", uart_active, 0);
    chk("no_early_swap", frame_count, 1);
    @(negedge clk_in);
    chk("f2_count", frame_count, 2);
    chk("f2_busy", uart_active, 1);
    chk("f2_rd_bank", rd_bank, 1);
    // Frame 3: taxel 5 never answers.
    silent = 5;
    wait_writes(48);
    silent = -1;
    chk("timeout_flag", adc_timeout, 1);
    pulse_done();
    @(negedge clk_in);
    chk("f3_count", frame_count, 3);
    // Frame 4: scan_enable drops mid-frame; frame still completes and is handed off.
    wait_writes(55);
    scan_enable = 0;
    wait_writes(64);
    repeat (5) @(negedge clk_in);
    pulse_done();
    @(negedge clk_in);
    chk("f4_count", frame_count, 4);
    repeat (60) @(negedge clk_in);
    chk("idle_writes", nwrites, 64);
    chk("idle_drive", sw_drive, 0);
    chk("idle_busy", uart_active, 1);
    chk("timeout_sticky", adc_timeout, 1);
    // Frame 5: asynchronous reset after taxel 9.
    scan_enable = 1;
    wait_writes(73);
    #2 rst_n_in = 0;
    #1;
    chk("arst_busy", uart_active, 0);
    chk("arst_count", frame_count, 0);
    chk("arst_timeout", adc_timeout, 0);
    chk("arst_drive", sw_drive, 0);
    chk("arst_sel", {sw_sel, rd_sel}, 0);
    chk("arst_rd_bank", rd_bank, 1);
    base = nwrites;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1;
    wait_active();
    chk("restart_writes", nwrites, base + 16);
    chk("restart_count", frame_count, 1);
    chk("restart_rd_bank", rd_bank, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
